// File: rtl/vend_change_dispenser_pkg.sv
// Shared vending definitions: coin denominations, dispenser states and the
// default width of change amounts.
package vend_change_dispenser_pkg;

  localparam int AMT_W_DEF = 5;

  // Coin face values, also used by the upstream vend controller
  localparam int DENOM_1  = 1;
  localparam int DENOM_5  = 5;
  localparam int DENOM_10 = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } disp_state_t;

  // Hopper request vector layout: {eject_10, eject_5, eject_1}
  typedef logic [2:0] eject_vec_t;

  localparam eject_vec_t EJ_NONE = 3'b000;
  localparam eject_vec_t EJ_10   = 3'b100;
  localparam eject_vec_t EJ_5    = 3'b010;
  localparam eject_vec_t EJ_1    = 3'b001;

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Change request, hopper handshake and status signals of the change dispenser.
interface vend_change_dispenser_if #(
  parameter int AMT_W = vend_change_dispenser_pkg::AMT_W_DEF
);

  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic             eject_10;
  logic             eject_5;
  logic             eject_1;
  logic             coin_ack;
  logic             empty_10;
  logic             empty_5;
  logic             empty_1;
  logic             fault_clear;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;

  // master: vend controller plus hoppers; slave: the dispenser
  modport master (
    output change_valid, change_amount, coin_ack,
    output empty_10, empty_5, empty_1, fault_clear,
    input  change_ready, eject_10, eject_5, eject_1,
    input  busy, done, fault, remaining
  );

  modport slave (
    input  change_valid, change_amount, coin_ack,
    input  empty_10, empty_5, empty_1, fault_clear,
    output change_ready, eject_10, eject_5, eject_1,
    output busy, done, fault, remaining
  );

endinterface

// File: rtl/vend_ack_timer.sv
// Cycle counter for an outstanding eject request; flags the increment that
// brings the count up to ACK_TIMEOUT.
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] LAST  = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Raised on the edge whose increment would reach the limit, so the request
  // is dropped after exactly ACK_TIMEOUT unacknowledged cycles.
  always_comb begin
    expire = inc && (count_q >= LAST);
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays a change amount out as 10/5/1 coins, largest stocked denomination
// first, one held eject request per coin with an acknowledge timeout.
module vend_change_dispenser
  import vend_change_dispenser_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   reset,
  vend_change_dispenser_if.slave bus
);

  localparam logic [AMT_W-1:0] D10 = AMT_W'(DENOM_10);
  localparam logic [AMT_W-1:0] D5  = AMT_W'(DENOM_5);
  localparam logic [AMT_W-1:0] D1  = AMT_W'(DENOM_1);

  disp_state_t      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  eject_vec_t       eject_q, eject_d;
  logic [AMT_W-1:0] denom_cur;
  logic             timer_inc;
  logic             timer_expire;

  // Value of the coin currently requested, recovered from the one-hot eject
  function automatic logic [AMT_W-1:0] denom_of(input eject_vec_t ej);
    if (ej[2]) begin
      return D10;
    end else if (ej[1]) begin
      return D5;
    end
    return D1;
  endfunction

  // Greedy pick: largest stocked coin not exceeding the balance, or none
  function automatic eject_vec_t pick_coin(input logic [AMT_W-1:0] bal,
                                           input logic e10,
                                           input logic e5,
                                           input logic e1);
    if ((bal >= D10) && !e10) begin
      return EJ_10;
    end else if ((bal >= D5) && !e5) begin
      return EJ_5;
    end else if ((bal >= D1) && !e1) begin
      return EJ_1;
    end
    return EJ_NONE;
  endfunction

  always_comb begin
    denom_cur = denom_of(eject_q);
    timer_inc = (state_q == ST_EJECT) && !bus.coin_ack;
  end

  // The timer runs only while a request waits; any other cycle clears it
  vend_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!timer_inc),
    .inc    (timer_inc),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      eject_q     <= EJ_NONE;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      eject_q     <= eject_d;
    end
  end

  always_comb begin
    eject_vec_t pick;
    state_d     = state_q;
    remaining_d = remaining_q;
    eject_d     = eject_q;
    pick        = pick_coin(remaining_q, bus.empty_10, bus.empty_5, bus.empty_1);

    case (state_q)
      ST_IDLE: begin
        eject_d = EJ_NONE;
        if (bus.change_valid) begin
          if (bus.change_amount != '0) begin
            remaining_d = bus.change_amount;
            state_d     = ST_SELECT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SELECT: begin
        if (pick != EJ_NONE) begin
          eject_d = pick;
          state_d = ST_EJECT;
        end else begin
          eject_d = EJ_NONE;
          state_d = ST_FAULT;
        end
      end

      // Hopper empties are not re-examined here; a pending request stands
      ST_EJECT: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - denom_cur;
          eject_d     = EJ_NONE;
          state_d     = (remaining_d == '0) ? ST_DONE : ST_SELECT;
        end else if (timer_expire) begin
          eject_d = EJ_NONE;
          state_d = ST_FAULT;
        end
      end

      ST_DONE: begin
        eject_d = EJ_NONE;
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        eject_d = EJ_NONE;
        if (bus.fault_clear) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        eject_d     = EJ_NONE;
        remaining_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.change_ready = (state_q == ST_IDLE);
    bus.busy         = (state_q == ST_SELECT) || (state_q == ST_EJECT) ||
                       (state_q == ST_DONE);
    bus.done         = (state_q == ST_DONE);
    bus.fault        = (state_q == ST_FAULT);
    bus.eject_10     = eject_q[2];
    bus.eject_5      = eject_q[1];
    bus.eject_1      = eject_q[0];
    bus.remaining    = remaining_q;
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: vector table, hand-written corner
// sequences and random payouts against a closed-form change model.
module tb_vend_change_dispenser;

  localparam int AMT_W       = 5;
  localparam int ACK_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vend_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  vend_change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amt;
    bit e10;
    bit e5;
    bit e1;
    int n10;
    int n5;
    int n1;
    bit flt;
    int rem;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int seq[$];
  int rems[$];
  int onehot_bad;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int exp[$], input int got[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    end
  endtask

  // Greedy change with unavailable hoppers skipped, in closed form
  function automatic void model(input int amt, input bit e10, input bit e5, input bit e1,
                                output int n10, output int n5, output int n1,
                                output bit flt, output int rem);
    int r;
    n10 = e10 ? 0 : amt / 10;
    r   = amt - 10 * n10;
    n5  = e5 ? 0 : r / 5;
    r   = r - 5 * n5;
    n1  = e1 ? 0 : r;
    rem = r - n1;
    flt = (rem != 0);
  endfunction

  // Issues one change request and plays the hoppers until done or fault
  task automatic run_txn(input int amt, input bit e10, input bit e5, input bit e1,
                         input int dmin, input int dmax,
                         output int n10, output int n5, output int n1,
                         output bit flt, output int rem_end, output bit ended);
    bit [2:0] cur, prev;
    int wait_cnt, guard;
    bit waiting;
    n10 = 0; n5 = 0; n1 = 0; flt = 0; rem_end = -1; ended = 0;
    seq.delete(); rems.delete(); onehot_bad = 0;
    bus.empty_10 = e10; bus.empty_5 = e5; bus.empty_1 = e1;
    guard = 0;
    while (!bus.change_ready && guard < 10) begin
      step();
      guard++;
    end
    bus.change_amount = AMT_W'(amt);
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    prev = 3'b000; waiting = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (bus.done) begin
        ended = 1; rem_end = int'(bus.remaining);
        break;
      end
      if (bus.fault) begin
        ended = 1; flt = 1; rem_end = int'(bus.remaining);
        break;
      end
      cur = {bus.eject_10, bus.eject_5, bus.eject_1};
      if ($countones(cur) > 1) onehot_bad++;
      if (cur != 3'b000 && prev == 3'b000) begin
        if (cur[2]) begin seq.push_back(10); n10++; end
        else if (cur[1]) begin seq.push_back(5); n5++; end
        else begin seq.push_back(1); n1++; end
        rems.push_back(int'(bus.remaining));
        wait_cnt = int'($urandom_range(dmax, dmin));
        waiting  = 1;
      end
      if (waiting) begin
        if (wait_cnt == 0) begin
          bus.coin_ack = 1'b1;
          waiting = 0;
        end else begin
          wait_cnt--;
        end
      end
      prev = cur;
      step();
      bus.coin_ack = 1'b0;
    end
  endtask

  task automatic clear_fault(input string name);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    check({name, "_clr_ready"}, int'(bus.change_ready), 1);
    check({name, "_clr_rem"}, int'(bus.remaining), 0);
    check({name, "_clr_fault"}, int'(bus.fault), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int n10, n5, n1, rem, en10, en5, en1, erem, hi_cnt;
    bit flt, ended, eflt;
    int e[$];

    vecs[0] = '{17, 0, 0, 0, 1, 1, 2, 0, 0};
    vecs[1] = '{17, 1, 0, 0, 0, 3, 2, 0, 0};
    vecs[2] = '{3,  0, 0, 1, 0, 0, 0, 1, 3};
    vecs[3] = '{0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{23, 0, 1, 0, 2, 0, 3, 0, 0};
    vecs[5] = '{9,  0, 0, 1, 0, 1, 0, 1, 4};
    vecs[6] = '{30, 1, 1, 0, 0, 0, 30, 0, 0};
    vecs[7] = '{14, 1, 1, 1, 0, 0, 0, 1, 14};
    vecs[8] = '{31, 0, 0, 0, 3, 0, 1, 0, 0};
    vecs[9] = '{8,  0, 1, 0, 0, 0, 8, 0, 0};

    bus.change_valid = 1'b0; bus.change_amount = '0; bus.coin_ack = 1'b0;
    bus.empty_10 = 1'b0; bus.empty_5 = 1'b0; bus.empty_1 = 1'b0;
    bus.fault_clear = 1'b0;

    // Asynchronous reset, observed before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_ready", int'(bus.change_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_rem", int'(bus.remaining), 0);
    check("rst_eject", int'({bus.eject_10, bus.eject_5, bus.eject_1}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Nominal 17 with ack three cycles after each eject rise
    run_txn(17, 0, 0, 0, 3, 3, n10, n5, n1, flt, rem, ended);
    check("nom_ended", int'(ended), 1);
    check("nom_fault", int'(flt), 0);
    check("nom_rem", rem, 0);
    e = {10, 5, 1, 1};
    check_seq("nom_seq", e, seq);
    e = {17, 7, 2, 1};
    check_seq("nom_rems", e, rems);
    step();
    check("nom_done_pulse", int'(bus.done), 0);

    // Empty 10 hopper falls back to fives
    run_txn(17, 1, 0, 0, 1, 2, n10, n5, n1, flt, rem, ended);
    check("fb_ended", int'(ended), 1);
    check("fb_fault", int'(flt), 0);
    check("fb_n10", n10, 0);
    e = {5, 5, 5, 1, 1};
    check_seq("fb_seq", e, seq);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].amt, vecs[i].e10, vecs[i].e5, vecs[i].e1, 0, 2,
              n10, n5, n1, flt, rem, ended);
      check($sformatf("vec%0d_ended", i), int'(ended), 1);
      check($sformatf("vec%0d_n10", i), n10, vecs[i].n10);
      check($sformatf("vec%0d_n5", i), n5, vecs[i].n5);
      check($sformatf("vec%0d_n1", i), n1, vecs[i].n1);
      check($sformatf("vec%0d_fault", i), int'(flt), int'(vecs[i].flt));
      check($sformatf("vec%0d_rem", i), rem, vecs[i].rem);
      check($sformatf("vec%0d_onehot", i), onehot_bad, 0);
      if (flt) clear_fault($sformatf("vec%0d", i));
      else begin
        step();
        check($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
      end
    end
    bus.empty_10 = 1'b0; bus.empty_5 = 1'b0; bus.empty_1 = 1'b0;
    step();

    // Unpayable amount: fault one cycle after SELECT, then ignored inputs
    bus.empty_1 = 1'b1;
    bus.change_amount = AMT_W'(3);
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    check("unp_select_busy", int'(bus.busy), 1);
    check("unp_select_fault", int'(bus.fault), 0);
    step();
    check("unp_fault", int'(bus.fault), 1);
    check("unp_rem", int'(bus.remaining), 3);
    check("unp_eject", int'({bus.eject_10, bus.eject_5, bus.eject_1}), 0);
    check("unp_busy", int'(bus.busy), 0);
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    check("unp_ack_fault", int'(bus.fault), 1);
    check("unp_ack_rem", int'(bus.remaining), 3);
    bus.change_amount = AMT_W'(7);
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    check("unp_valid_fault", int'(bus.fault), 1);
    check("unp_valid_rem", int'(bus.remaining), 3);
    check("unp_valid_ready", int'(bus.change_ready), 0);
    clear_fault("unp");
    bus.empty_1 = 1'b0;

    // Ack timeout; toggling empty_5 mid-request must not abort it
    bus.change_amount = AMT_W'(5);
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 3) bus.empty_5 = 1'b1;
      if (bus.fault) break;
      if (bus.eject_5) hi_cnt++;
    end
    bus.empty_5 = 1'b0;
    check("to_eject_cycles", hi_cnt, ACK_TIMEOUT);
    check("to_fault", int'(bus.fault), 1);
    check("to_eject_off", int'(bus.eject_5), 0);
    check("to_rem", int'(bus.remaining), 5);
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    check("to_stray_rem", int'(bus.remaining), 5);
    check("to_stray_fault", int'(bus.fault), 1);
    clear_fault("to");

    // Zero amount and stray ack in IDLE
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    check("zero_stray_ready", int'(bus.change_ready), 1);
    check("zero_stray_busy", int'(bus.busy), 0);
    check("zero_stray_rem", int'(bus.remaining), 0);
    bus.change_amount = '0;
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 1);
    check("zero_eject", int'({bus.eject_10, bus.eject_5, bus.eject_1}), 0);
    step();
    check("zero_done_end", int'(bus.done), 0);
    check("zero_busy_end", int'(bus.busy), 0);
    check("zero_ready_end", int'(bus.change_ready), 1);

    // Reset while eject_10 is pending with 12 left
    bus.change_amount = AMT_W'(22);
    bus.change_valid  = 1'b1;
    step();
    bus.change_valid = 1'b0;
    step();
    check("mid_eject10_a", int'(bus.eject_10), 1);
    check("mid_rem_a", int'(bus.remaining), 22);
    bus.coin_ack = 1'b1;
    step();
    bus.coin_ack = 1'b0;
    check("mid_rem_b", int'(bus.remaining), 12);
    step();
    check("mid_eject10_b", int'(bus.eject_10), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_eject10", int'(bus.eject_10), 0);
    check("mid_rst_rem", int'(bus.remaining), 0);
    check("mid_rst_ready", int'(bus.change_ready), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    run_txn(6, 0, 0, 0, 0, 3, n10, n5, n1, flt, rem, ended);
    check("mid_after_ended", int'(ended), 1);
    check("mid_after_fault", int'(flt), 0);
    e = {5, 1};
    check_seq("mid_after_seq", e, seq);

    // Random payouts against the closed-form model
    for (int t = 0; t < 40; t++) begin
      int amt;
      bit r10, r5, r1;
      amt = int'($urandom_range(31, 0));
      r10 = ($urandom_range(3, 0) == 0);
      r5  = ($urandom_range(3, 0) == 0);
      r1  = ($urandom_range(3, 0) == 0);
      model(amt, r10, r5, r1, en10, en5, en1, eflt, erem);
      run_txn(amt, r10, r5, r1, 0, 5, n10, n5, n1, flt, rem, ended);
      check($sformatf("rnd%0d_ended", t), int'(ended), 1);
      check($sformatf("rnd%0d_n10", t), n10, en10);
      check($sformatf("rnd%0d_n5", t), n5, en5);
      check($sformatf("rnd%0d_n1", t), n1, en1);
      check($sformatf("rnd%0d_fault", t), int'(flt), int'(eflt));
      check($sformatf("rnd%0d_rem", t), rem, erem);
      check($sformatf("rnd%0d_onehot", t), onehot_bad, 0);
      if (flt) clear_fault($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
